// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver/host side and the receive FIFO.
// The master drives strobes, control and ready; the slave (FIFO) drives data and status.
interface uart_rx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  re;
   logic                  error;
   logic [7:0]            datai;
   logic                  clear;
   logic                  ov_clr;
   logic [DEPTH_LOG2:0]   thresh;
   logic [7:0]            dout;
   logic                  dout_error;
   logic                  dout_valid;
   logic                  dout_ready;
   logic [DEPTH_LOG2:0]   count;
   logic                  full;
   logic                  empty;
   logic                  overflow;
   logic                  level_irq;
   logic [7:0]            err_count;

   modport master (
      output re, error, datai, clear, ov_clr, thresh, dout_ready,
      input  dout, dout_error, dout_valid, count, full, empty, overflow, level_irq, err_count
   );

   modport slave (
      input  re, error, datai, clear, ov_clr, thresh, dout_ready,
      output dout, dout_error, dout_valid, count, full, empty, overflow, level_irq, err_count
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: stores bytes with an error tag, flags overflow,
// raises a fill-level interrupt and keeps a saturating error-strobe counter.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2  = 4,
   parameter bit DROP_ERRORS = 1'b0
) (
   input  logic            clk,
   input  logic            resetb,
   uart_rx_fifo_if.slave   rx
);
   localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
   localparam int                  CW       = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0]       FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [8:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_nxt;
   logic                  ovf;
   logic                  irq;
   logic [7:0]            errs;
   logic                  wr;
   logic                  pop;
   logic                  is_full;
   logic                  has_data;
   logic                  accept;
   logic                  drop;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign is_full  = (cnt == FULL_CNT);
   assign has_data = (cnt != '0);
   assign wr       = rx.re | (rx.error & ~DROP_ERRORS);
   assign pop      = has_data & rx.dout_ready;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign accept   = wr & (~is_full | pop);
   assign drop     = wr & is_full & ~pop;

   always_comb begin
      cnt_nxt = cnt;
      if (rx.clear)
         cnt_nxt = '0;
      else if (accept && !pop)
         cnt_nxt = cnt + CNT_ONE;
      else if (pop && !accept)
         cnt_nxt = cnt - CNT_ONE;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         irq    <= 1'b0;
         errs   <= 8'd0;
      end else if (rx.clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         irq    <= 1'b0;
         errs   <= 8'd0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
         cnt <= cnt_nxt;
         if (drop)
            ovf <= 1'b1;
         else if (rx.ov_clr)
            ovf <= 1'b0;
         if (rx.error) errs <= sat_inc(errs);
         irq <= (rx.thresh != '0) && (cnt_nxt >= rx.thresh);
      end
   end

   // Storage carries no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (accept && !rx.clear)
         mem[wr_ptr] <= {rx.error, rx.datai};
   end

   assign rx.dout       = has_data ? mem[rd_ptr][7:0] : 8'h00;
   assign rx.dout_error = has_data ? mem[rd_ptr][8]   : 1'b0;
   assign rx.dout_valid = has_data;
   assign rx.count      = cnt;
   assign rx.full       = is_full;
   assign rx.empty      = ~has_data;
   assign rx.overflow   = ovf;
   assign rx.level_irq  = irq;
   assign rx.err_count  = errs;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random strobes checked against a queue-based model,
// plus a second instance with errored bytes dropped.
module tb_uart_rx_fifo;
   localparam int DL    = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic resetb = 1'b0;
   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DEPTH_LOG2(DL)) ifa ();
   uart_rx_fifo_if #(.DEPTH_LOG2(DL)) ifb ();

   uart_rx_fifo #(.DEPTH_LOG2(DL), .DROP_ERRORS(1'b0)) dut_keep (
      .clk(clk), .resetb(resetb), .rx(ifa.slave));
   uart_rx_fifo #(.DEPTH_LOG2(DL), .DROP_ERRORS(1'b1)) dut_drop (
      .clk(clk), .resetb(resetb), .rx(ifb.slave));

   logic [8:0] q[$];
   int         m_err;
   bit         m_ov;
   int         total = 0;
   int         fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_err = 0;
      m_ov  = 1'b0;
   endtask

   task automatic check_a(input string ph);
      int n;
      bit irq;
      n   = q.size();
      irq = (ifa.thresh != '0) && (n >= int'(ifa.thresh));
      chk({ph, ".count"},     32'(ifa.count),      32'(n));
      chk({ph, ".full"},      32'(ifa.full),       32'(n == DEPTH));
      chk({ph, ".empty"},     32'(ifa.empty),      32'(n == 0));
      chk({ph, ".valid"},     32'(ifa.dout_valid), 32'(n != 0));
      chk({ph, ".overflow"},  32'(ifa.overflow),   32'(m_ov));
      chk({ph, ".level_irq"}, 32'(ifa.level_irq),  32'(irq));
      chk({ph, ".err_count"}, 32'(ifa.err_count),  32'(m_err));
      if (n != 0) begin
         chk({ph, ".dout"},       32'(ifa.dout),       32'(q[0][7:0]));
         chk({ph, ".dout_error"}, 32'(ifa.dout_error), 32'(q[0][8]));
      end
   endtask

   // One clock of stimulus on instance A; the model applies the same cycle's rules.
   task automatic step(input string ph, input bit r, input bit e, input logic [7:0] d,
                       input bit rdy, input bit clr, input bit oc);
      bit pop, wr, set;
      ifa.re = r; ifa.error = e; ifa.datai = d;
      ifa.dout_ready = rdy; ifa.clear = clr; ifa.ov_clr = oc;
      @(posedge clk);
      pop = (q.size() > 0) && rdy;
      wr  = r || e;
      if (clr) begin
         model_reset();
      end else begin
         set = wr && (q.size() == DEPTH) && !pop;
         if (pop) void'(q.pop_front());
         if (wr && !set) q.push_back({e, d});
         if (set) m_ov = 1'b1;
         else if (oc) m_ov = 1'b0;
         if (e && m_err < 255) m_err++;
      end
      #1;
      ifa.re = 1'b0; ifa.error = 1'b0; ifa.dout_ready = 1'b0;
      ifa.clear = 1'b0; ifa.ov_clr = 1'b0;
      check_a(ph);
   endtask

   initial begin
      int  nw;
      bit  r, p;
      ifa.re = 0; ifa.error = 0; ifa.datai = 0; ifa.clear = 0; ifa.ov_clr = 0;
      ifa.thresh = '0; ifa.dout_ready = 0;
      ifb.re = 0; ifb.error = 0; ifb.datai = 0; ifb.clear = 0; ifb.ov_clr = 0;
      ifb.thresh = '0; ifb.dout_ready = 0;
      model_reset();

      // Reset state
      #12;
      check_a("rst");
      chk("rst.dout",       32'(ifa.dout),       32'h0);
      chk("rst.dout_error", 32'(ifa.dout_error), 32'h0);
      chk("rst.b_empty",    32'(ifb.empty),      32'h1);
      @(negedge clk);
      resetb = 1'b1;
      @(posedge clk); #1;

      // Single byte
      repeat (8) step("idle", 0, 0, 8'h00, 0, 0, 0);
      step("single", 1, 0, 8'h55, 0, 0, 0);
      chk("single.dout", 32'(ifa.dout), 32'h55);
      step("single.hold", 0, 0, 8'h00, 0, 0, 0);
      chk("single.hold_dout", 32'(ifa.dout), 32'h55);
      step("single.pop", 0, 0, 8'h00, 1, 0, 0);
      chk("single.empty", 32'(ifa.empty), 32'h1);

      // Fill to overflow and drain
      for (int i = 0; i < 17; i++) step("fill", 1, 0, 8'(i), 0, 0, 0);
      chk("fill.full", 32'(ifa.full), 32'h1);
      chk("fill.overflow", 32'(ifa.overflow), 32'h1);
      for (int i = 0; i < 16; i++) begin
         chk("drain.order", 32'(ifa.dout), 32'(i));
         step("drain", 0, 0, 8'h00, 1, 0, 0);
      end
      chk("drain.overflow_sticky", 32'(ifa.overflow), 32'h1);
      step("ovclr", 0, 0, 8'h00, 0, 0, 1);
      chk("ovclr.overflow", 32'(ifa.overflow), 32'h0);

      // Pointer wrap with low occupancy
      nw = 0;
      while (nw < 40) begin
         r = (q.size() < 5) && ((q.size() == 0) || (($urandom & 1) != 0));
         p = (q.size() > 1) && (($urandom & 1) != 0);
         step("wrap", r, 0, 8'($urandom), p, 0, 0);
         if (r) nw++;
      end
      while (q.size() > 0) step("wrap.drain", 0, 0, 8'h00, 1, 0, 0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 16; i++) step("pp.fill", 1, 0, 8'($urandom_range(0, 127)), 0, 0, 0);
      step("pp.both", 1, 0, 8'hA5, 1, 0, 0);
      chk("pp.count", 32'(ifa.count), 32'd16);
      chk("pp.overflow", 32'(ifa.overflow), 32'h0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("pp.a5_16th", 32'(ifa.dout), 32'hA5);
         step("pp.drain", 0, 0, 8'h00, 1, 0, 0);
      end

      // Error strobes, both instances
      ifb.error = 1'b1; ifb.datai = 8'h3C;
      step("err.keep", 0, 1, 8'h3C, 0, 0, 0);
      ifb.error = 1'b0;
      chk("err.keep_tag", 32'(ifa.dout_error), 32'h1);
      chk("err.keep_cnt", 32'(ifa.err_count), 32'h1);
      chk("err.drop_count", 32'(ifb.count), 32'h0);
      chk("err.drop_empty", 32'(ifb.empty), 32'h1);
      chk("err.drop_errcnt", 32'(ifb.err_count), 32'h1);
      ifb.re = 1'b1; ifb.error = 1'b1; ifb.datai = 8'h77;
      step("err.pop", 0, 0, 8'h00, 1, 0, 0);
      ifb.re = 1'b0; ifb.error = 1'b0;
      chk("err.drop_both_count", 32'(ifb.count), 32'h1);
      chk("err.drop_both_dout", 32'(ifb.dout), 32'h77);
      chk("err.drop_both_tag", 32'(ifb.dout_error), 32'h1);
      chk("err.drop_both_errcnt", 32'(ifb.err_count), 32'h2);
      for (int i = 0; i < 300; i++) step("err.sat", 0, 1, 8'($urandom), 1, 0, 0);
      chk("err.sat255", 32'(ifa.err_count), 32'd255);
      while (q.size() > 0) step("err.drain", 0, 0, 8'h00, 1, 0, 0);

      // Random mixed traffic
      for (int i = 0; i < 200; i++) begin
         if ((i % 40) == 0) ifa.thresh = 5'($urandom_range(0, 16));
         step("rand", ($urandom % 3) != 0, ($urandom % 5) == 0, 8'($urandom),
              ($urandom % 3) == 0, ($urandom % 60) == 0, ($urandom % 7) == 0);
      end

      // Threshold interrupt and clear
      step("thr.clr", 0, 0, 8'h00, 0, 1, 0);
      ifa.thresh = 5'd3;
      step("thr.w1", 1, 0, 8'h11, 0, 0, 0);
      step("thr.w2", 1, 0, 8'h22, 0, 0, 0);
      chk("thr.irq_below", 32'(ifa.level_irq), 32'h0);
      step("thr.w3", 1, 1, 8'h33, 0, 0, 0);
      chk("thr.irq_at3", 32'(ifa.level_irq), 32'h1);
      step("thr.clear", 1, 0, 8'h44, 0, 1, 0);
      chk("thr.clear_count", 32'(ifa.count), 32'h0);
      chk("thr.clear_irq", 32'(ifa.level_irq), 32'h0);
      chk("thr.clear_err", 32'(ifa.err_count), 32'h0);
      step("thr.after", 0, 0, 8'h00, 0, 0, 0);

      // Asynchronous reset mid-transfer
      step("arst.pre", 1, 0, 8'h9A, 0, 0, 0);
      ifa.re = 1'b1; ifa.datai = 8'hEE;
      #2 resetb = 1'b0;
      #1 model_reset();
      check_a("arst.now");
      @(posedge clk); #1;
      check_a("arst.held");
      ifa.re = 1'b0;
      resetb = 1'b1;
      step("arst.after", 0, 0, 8'h00, 0, 0, 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
